psum_accum: RTL and testbench



---
 rtl/psum_accum.sv | 109 ++++++++++
 tb/tb_psum_accum.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/psum_accum.sv
// Accumulates a programmed number of signed partial sums into a saturating accumulator and presents the result on a valid/ready port.
// Optional build macro PSUM_ACCUM_RELU_EN clamps negative results to zero on out_data.
module psum_accum #(
  parameter int psum_bw = 16,
  parameter int acc_bw  = 24,
  parameter int cnt_bw  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [psum_bw-1:0] in_psum,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [acc_bw-1:0] out_data,
  output logic              ovf,
  output logic              busy
);

  // Handshakes: a transfer happens on a port in any cycle where valid && ready
  // are both high at the rising edge; ready/valid here depend only on state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [cnt_bw-1:0] cnt_one = cnt_bw'(1);
  localparam logic [acc_bw-1:0] acc_max = {1'b0, {(acc_bw-1){1'b1}}};
  localparam logic [acc_bw-1:0] acc_min = {1'b1, {(acc_bw-1){1'b0}}};

  state_t            state;
  state_t            state_next;
  logic [cnt_bw-1:0] len_q;
  logic [cnt_bw-1:0] cnt;
  logic [acc_bw-1:0] acc;
  logic              ovf_q;
  logic              accept;
  logic              take_start;
  logic              last_beat;
  logic [acc_bw:0]   sum_wide;
  logic              sum_ovf;
  logic [acc_bw-1:0] sum_sat;

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == HOLD);
  assign busy       = (state != IDLE);
  assign ovf        = ovf_q;
  assign accept     = in_ready && in_valid;
  assign take_start = start && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign last_beat  = ((cnt + cnt_one) == len_q);

  // One guard bit: overflow shows up as the two top bits disagreeing.
  assign sum_wide = {acc[acc_bw-1], acc}
                  + {{(acc_bw+1-psum_bw){in_psum[psum_bw-1]}}, in_psum};
  assign sum_ovf  = (sum_wide[acc_bw] != sum_wide[acc_bw-1]);
  assign sum_sat  = !sum_ovf ? sum_wide[acc_bw-1:0]
                  : (sum_wide[acc_bw] ? acc_min : acc_max);

`ifdef PSUM_ACCUM_RELU_EN
  assign out_data = acc[acc_bw-1] ? '0 : acc;
`else
  assign out_data = acc;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (take_start) state_next = (len == '0) ? HOLD : ACCUM;
      end
      ACCUM: begin
        if (accept && last_beat) state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          if (take_start) state_next = (len == '0) ? HOLD : ACCUM;
          else            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      len_q <= '0;
      cnt   <= '0;
      acc   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_next;
      if (take_start) begin
        len_q <= len;
        cnt   <= '0;
        acc   <= '0;
        ovf_q <= 1'b0;
      end else if (accept) begin
        cnt   <= cnt + cnt_one;
        acc   <= sum_sat;
        ovf_q <= ovf_q | sum_ovf;
      end
    end
  end

endmodule

// File: tb/tb_psum_accum.sv
// Directed bench for psum_accum built with an 18-bit accumulator so saturation is reachable with 16-bit inputs.
// Expected results are hand-computed; the optional ReLU build is honoured through the same macro.
module tb_psum_accum;

  localparam int PW = 16;
  localparam int AW = 18;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [CW-1:0] len;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_psum;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic          ovf;
  logic          busy;

  int passed = 0;
  int total  = 0;

  psum_accum #(.psum_bw(PW), .acc_bw(AW), .cnt_bw(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_psum(in_psum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]        len;
    logic [7:0][PW-1:0]   v;
    logic [3:0]           gap;
    logic [AW-1:0]        exp_data;
    logic                 exp_ovf;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(int l, int g, int e, bit o,
                              int a0 = 0, int a1 = 0, int a2 = 0,
                              int a3 = 0, int a4 = 0, int a5 = 0);
    vec_t t;
    t          = '0;
    t.len      = CW'(l);
    t.gap      = 4'(g);
    t.exp_data = AW'(e);
    t.exp_ovf  = o;
    t.v[0] = PW'(a0); t.v[1] = PW'(a1); t.v[2] = PW'(a2);
    t.v[3] = PW'(a3); t.v[4] = PW'(a4); t.v[5] = PW'(a5);
    return t;
  endfunction

  function automatic logic [AW-1:0] exp_out(logic [AW-1:0] e);
`ifdef PSUM_ACCUM_RELU_EN
    return e[AW-1] ? '0 : e;
`else
    return e;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_job(input vec_t t);
    start = 1'b1;
    len   = t.len;
    tick();
    start = 1'b0;
    len   = 8'hAA;  // later len changes must not matter
    check("start_in_ready", 32'(in_ready), 32'(t.len != 0));
    check("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < int'(t.len); i++) begin
      if (i > 0) begin
        for (int g = 0; g < int'(t.gap); g++) begin
          in_valid = 1'b0;
          tick();
          check("gap_in_ready", 32'(in_ready), 32'd1);
        end
      end
      check("beat_no_out_valid", 32'(out_valid), 32'd0);
      in_valid = 1'b1;
      in_psum  = t.v[i];
      tick();
      in_valid = 1'b0;
    end
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("hold_in_ready", 32'(in_ready), 32'd0);
    check("out_data", 32'(out_data), 32'(exp_out(t.exp_data)));
    check("ovf", 32'(ovf), 32'(t.exp_ovf));
    drain();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_psum = '0; out_ready = 1'b0;
    vecs[0] = mk(4, 0, 32, 0, 10, 20, -5, 7);
    vecs[1] = mk(3, 2, -150, 0, 100, -300, 50);
    vecs[2] = mk(0, 0, 0, 0);
    vecs[3] = mk(5, 0, 131071, 1, 32767, 32767, 32767, 32767, 32767);
    vecs[4] = mk(1, 0, 1, 0, 1);
    vecs[5] = mk(5, 1, -131072, 1, -32768, -32768, -32768, -32768, -32768);
    vecs[6] = mk(2, 0, -1, 0, -32768, 32767);
    vecs[7] = mk(3, 0, 32766, 0, 32767, 32767, -32768);
    vecs[8] = mk(6, 0, 98303, 1, 32767, 32767, 32767, 32767, 32767, -32768);

    tick(); tick();
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    for (int k = 0; k < 9; k++) run_job(vecs[k]);

    // Backpressure, ignored start in HOLD, then back-to-back restart on the handshake.
    start = 1'b1; len = 8'd1; tick();
    start = 1'b0; in_valid = 1'b1; in_psum = 16'd9; tick();
    in_valid = 1'b0;
    check("bp_out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin start = 1'b1; len = 8'd7; end
      tick();
      start = 1'b0;
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_stable_data", 32'(out_data), 32'd9);
      check("bp_stable_ovf", 32'(ovf), 32'd0);
    end
    out_ready = 1'b1; start = 1'b1; len = 8'd2; tick();
    out_ready = 1'b0; start = 1'b0; len = 8'd5;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    check("b2b_out_valid", 32'(out_valid), 32'd0);
    check("b2b_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_psum = 16'd1; tick();
    in_psum = 16'd2; tick();
    in_valid = 1'b0;
    check("b2b_done", 32'(out_valid), 32'd1);
    check("b2b_data", 32'(out_data), 32'd3);
    drain();

    // Start ignored in ACCUM, then reset aborts the accumulation.
    start = 1'b1; len = 8'd4; tick();
    start = 1'b0;
    in_valid = 1'b1; in_psum = 16'd100; tick();
    start = 1'b1; len = 8'd1; in_psum = 16'd200; tick();
    start = 1'b0; in_valid = 1'b0;
    check("accum_start_ignored_ready", 32'(in_ready), 32'd1);
    check("accum_start_ignored_valid", 32'(out_valid), 32'd0);
    reset = 1'b1; tick();
    reset = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    in_valid = 1'b1; in_psum = 16'd77; tick();
    in_valid = 1'b0;
    check("idle_no_accept", 32'(busy), 32'd0);
    check("idle_no_out_valid", 32'(out_valid), 32'd0);
    run_job(mk(1, 0, 5, 0, 5));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
